// File: rtl/reg_slv_pkg.sv
// reg_slv_pkg: shared widths, error read-data constant and FSM state type for the register slave
package reg_slv_pkg;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] ERR_RDATA = '0;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
endpackage

// File: rtl/reg_slv_decode.sv
// reg_slv_decode: window hit, security violation and offset for an incoming request
// Ports: addr_i/non_sec_i request fields; hit_o inside window, sec_viol_o secure-only breach,
//        offset_o address relative to BASE_ADDR.
module reg_slv_decode import reg_slv_pkg::*; #(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE  = 'h1000,
    parameter bit                    SEC_ONLY   = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  non_sec_i,
    output logic                  hit_o,
    output logic                  sec_viol_o,
    output logic [ADDR_WIDTH-1:0] offset_o
);
    assign offset_o   = addr_i - BASE_ADDR;
    assign hit_o      = (addr_i >= BASE_ADDR) && (offset_o < ADDR_SIZE);
    assign sec_viol_o = SEC_ONLY && non_sec_i;
endmodule

// File: rtl/reg_slv_fsm.sv
// reg_slv_fsm: checks a request pulse, forwards it to the register file and returns a one-cycle ack
// Ports: req_*_i upstream request, abort_i cancel; ack_vld_o/rd_data_o/err_o upstream response;
//        reg_*_o downstream request and abort, reg_*_i downstream response; proto_err_o busy overlap.
module reg_slv_fsm import reg_slv_pkg::*; #(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DATA_WIDTH = DATA_W,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE  = 'h1000,
    parameter bit                    SEC_ONLY   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_wr_en_i,
    input  logic                  req_rd_en_i,
    input  logic [DATA_WIDTH-1:0] req_wr_data_i,
    input  logic                  req_non_sec_i,
    input  logic                  abort_i,
    output logic                  ack_vld_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  err_o,
    output logic                  reg_req_vld_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic                  reg_wr_en_o,
    output logic                  reg_rd_en_o,
    output logic [DATA_WIDTH-1:0] reg_wr_data_o,
    output logic                  reg_abort_o,
    input  logic                  reg_ack_vld_i,
    input  logic [DATA_WIDTH-1:0] reg_rd_data_i,
    input  logic                  reg_err_i,
    output logic                  proto_err_o
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, offset;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  wr_q, wr_d, rd_q, rd_d, err_q, err_d;
    logic                  hit, sec_viol, bad_req, busy;

    reg_slv_decode #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_SIZE (ADDR_SIZE),
        .SEC_ONLY  (SEC_ONLY)
    ) u_decode (
        .addr_i    (req_addr_i),
        .non_sec_i (req_non_sec_i),
        .hit_o     (hit),
        .sec_viol_o(sec_viol),
        .offset_o  (offset)
    );

    // a request must carry exactly one strobe to be forwarded
    assign bad_req = ~hit | sec_viol | (req_wr_en_i == req_rd_en_i);
    assign busy    = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_vld_i) begin
                addr_d  = offset;
                wr_d    = req_wr_en_i;
                rd_d    = req_rd_en_i;
                wdata_d = req_wr_data_i;
                rdata_d = DATA_WIDTH'(ERR_RDATA);
                err_d   = bad_req;
                state_d = bad_req ? RESP : REQ;
            end
            REQ, WAIT: begin
                if (abort_i) state_d = IDLE;
                else if (reg_ack_vld_i) begin
                    rdata_d = rd_q ? reg_rd_data_i : '0;
                    err_d   = reg_err_i;
                    state_d = RESP;
                end else state_d = WAIT;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // abort in RESP suppresses the ack in the same cycle
    assign ack_vld_o     = (state_q == RESP) && !abort_i;
    assign rd_data_o     = ack_vld_o ? rdata_q : '0;
    assign err_o         = ack_vld_o & err_q;
    assign reg_req_vld_o = state_q == REQ;
    assign reg_addr_o    = reg_req_vld_o ? addr_q : '0;
    assign reg_wr_en_o   = reg_req_vld_o & wr_q;
    assign reg_rd_en_o   = reg_req_vld_o & rd_q;
    assign reg_wr_data_o = reg_req_vld_o ? wdata_q : '0;
    assign reg_abort_o   = busy & abort_i & ~rst;
    assign proto_err_o   = busy & req_vld_i;
endmodule

// File: tb/tb_reg_slv_fsm.sv
// tb_reg_slv_fsm: randomized transaction-level check of reg_slv_fsm against a timeline model
module tb_reg_slv_fsm;
    localparam logic [47:0] BASE = 48'h1000;
    localparam logic [47:0] SIZE = 48'h1000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_vld_i = 1'b0, req_wr_en_i = 1'b0, req_rd_en_i = 1'b0, req_non_sec_i = 1'b0;
    logic [47:0] req_addr_i = '0;
    logic [31:0] req_wr_data_i = '0;
    logic        abort_i = 1'b0, reg_ack_vld_i = 1'b0, reg_err_i = 1'b0;
    logic [31:0] reg_rd_data_i = '0;
    logic        ack_vld_o, err_o, reg_req_vld_o, reg_wr_en_o, reg_rd_en_o, reg_abort_o, proto_err_o;
    logic [31:0] rd_data_o, reg_wr_data_o;
    logic [47:0] reg_addr_o;
    int total = 0, bad = 0;

    reg_slv_fsm #(.ADDR_WIDTH(48), .DATA_WIDTH(32), .BASE_ADDR(BASE), .ADDR_SIZE(SIZE), .SEC_ONLY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld_i), .req_addr_i(req_addr_i), .req_wr_en_i(req_wr_en_i),
        .req_rd_en_i(req_rd_en_i), .req_wr_data_i(req_wr_data_i), .req_non_sec_i(req_non_sec_i),
        .abort_i(abort_i), .ack_vld_o(ack_vld_o), .rd_data_o(rd_data_o), .err_o(err_o),
        .reg_req_vld_o(reg_req_vld_o), .reg_addr_o(reg_addr_o), .reg_wr_en_o(reg_wr_en_o),
        .reg_rd_en_o(reg_rd_en_o), .reg_wr_data_o(reg_wr_data_o), .reg_abort_o(reg_abort_o),
        .reg_ack_vld_i(reg_ack_vld_i), .reg_rd_data_i(reg_rd_data_i), .reg_err_i(reg_err_i),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outs(input bit rq, input logic [47:0] ra, input bit rw, input bit rr,
                            input logic [31:0] rwd, input bit ack, input logic [31:0] rdd,
                            input bit er, input bit ab, input bit pe);
        chk("reg_req_vld", 64'(reg_req_vld_o), 64'(rq));
        chk("reg_addr", 64'(reg_addr_o), 64'(ra));
        chk("reg_wr_en", 64'(reg_wr_en_o), 64'(rw));
        chk("reg_rd_en", 64'(reg_rd_en_o), 64'(rr));
        chk("reg_wr_data", 64'(reg_wr_data_o), 64'(rwd));
        chk("ack_vld", 64'(ack_vld_o), 64'(ack));
        chk("rd_data", 64'(rd_data_o), 64'(rdd));
        chk("err", 64'(err_o), 64'(er));
        chk("reg_abort", 64'(reg_abort_o), 64'(ab));
        chk("proto_err", 64'(proto_err_o), 64'(pe));
    endtask

    function automatic bit rejected(input logic [47:0] addr, input bit wr, input bit rd, input bit ns);
        return !(addr >= BASE && addr < BASE + SIZE) || ns || (wr == rd);
    endfunction

    function automatic int resp_cycle(input logic [47:0] addr, input bit wr, input bit rd, input bit ns, input int n);
        return rejected(addr, wr, rd, ns) ? 1 : 2 + n;
    endfunction

    // n: register-file wait states; a: abort cycle; ov: overlapping request cycle; r: reset cycle (0 = none)
    task automatic txn(input logic [47:0] addr, input bit wr, input bit rd, input bit ns,
                       input int n, input int a, input int ov, input int r);
        bit de, fwd, ack;
        int resp, last;
        logic [31:0] wd, rdat;
        bit rerr;
        de   = rejected(addr, wr, rd, ns);
        resp = resp_cycle(addr, wr, rd, ns, n);
        last = (r > 0) ? r : (a > 0) ? a : resp;
        wd   = $urandom;
        rdat = '0;
        rerr = 1'b0;
        @(posedge clk); #1;
        req_vld_i = 1'b1; req_addr_i = addr; req_wr_en_i = wr; req_rd_en_i = rd;
        req_non_sec_i = ns; req_wr_data_i = wd;
        abort_i = 1'($urandom); reg_ack_vld_i = 1'($urandom);
        reg_rd_data_i = $urandom; reg_err_i = 1'($urandom);
        @(negedge clk);
        chk_outs(0, '0, 0, 0, '0, 0, '0, 0, 0, 0);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            req_vld_i = (c == ov); req_addr_i = 48'({$urandom, $urandom});
            req_wr_en_i = 1'($urandom); req_rd_en_i = 1'($urandom); req_non_sec_i = 1'($urandom);
            req_wr_data_i = $urandom;
            abort_i = (c == a); rst = (c == r);
            reg_ack_vld_i = !de && (c == 1 + n);
            reg_rd_data_i = $urandom; reg_err_i = 1'($urandom);
            if (reg_ack_vld_i) begin
                rdat = rd ? reg_rd_data_i : '0;
                rerr = reg_err_i;
            end
            @(negedge clk);
            if (c != r) begin
                fwd = !de && (c == 1);
                ack = (c == resp) && (c != a);
                chk_outs(fwd, fwd ? addr - BASE : '0, fwd && wr, fwd && rd, fwd ? wd : '0,
                         ack, ack && !de ? rdat : '0, ack && (de || rerr), c == a, c == ov);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; req_vld_i = 1'b0; abort_i = 1'($urandom);
        reg_ack_vld_i = 1'($urandom); reg_rd_data_i = $urandom; reg_err_i = 1'($urandom);
        @(negedge clk);
        chk_outs(0, '0, 0, 0, '0, 0, '0, 0, 0, 0);
        abort_i = 1'b0; reg_ack_vld_i = 1'b0;
    endtask

    initial begin
        logic [47:0] addr;
        bit wr, rd, ns;
        int n, a, ov, r, resp, mode, sel;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outs(0, '0, 0, 0, '0, 0, '0, 0, 0, 0);
        txn(48'h1004, 0, 1, 0, 0, 0, 0, 0);
        txn(48'h1008, 1, 0, 0, 3, 0, 0, 0);
        txn(48'h2000, 0, 1, 0, 0, 0, 0, 0);
        txn(48'h1000, 0, 1, 1, 0, 0, 0, 0);
        txn(48'h1010, 0, 1, 0, 2, 3, 0, 0);
        txn(48'h1014, 0, 1, 0, 2, 0, 2, 0);
        txn(48'h1018, 0, 1, 0, 3, 0, 0, 2);
        txn(48'h1ffc, 0, 1, 0, 0, 0, 0, 0);
        txn(48'h1020, 1, 1, 0, 0, 0, 0, 0);
        txn(48'h1024, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(5, 0);
            addr = (sel == 0) ? BASE + 48'($urandom_range(32'hfff, 0)) :
                   (sel == 1) ? BASE - 48'd1 : (sel == 2) ? BASE :
                   (sel == 3) ? BASE + SIZE - 48'd1 : (sel == 4) ? BASE + SIZE :
                   48'({$urandom, $urandom});
            if (sel == 5 && $urandom_range(1, 0) == 0) addr = BASE + 48'($urandom_range(32'hfff, 0));
            sel = $urandom_range(7, 0);
            wr = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : sel[0];
            rd = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : !sel[0];
            ns = ($urandom_range(3, 0) == 0);
            n = $urandom_range(3, 0);
            resp = resp_cycle(addr, wr, rd, ns, n);
            mode = $urandom_range(3, 0);
            a  = (mode == 1) ? $urandom_range(resp, 1) : 0;
            ov = (mode == 2) ? $urandom_range(resp, 1) : 0;
            r  = (mode == 3) ? $urandom_range(resp, 1) : 0;
            txn(addr, wr, rd, ns, n, a, ov, r);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
